// File: rtl/flit_sink_pkg.sv
// flit_sink_pkg: shared state encoding, default sizes and accumulator sizing helper
package flit_sink_pkg;
  typedef enum logic [1:0] {IDLE, RECV, REPORT} state_t;
  localparam int FLIT_W_DEF = 54;
  localparam int OP_W_DEF = 27;
  localparam int PAYLOAD_DEF = 20;
  function automatic int acc_w_min(input int payload, input int flit_w);
    return $clog2(payload * flit_w + 1);
  endfunction
endpackage

// File: rtl/popcount.sv
// popcount: combinational count of set bits in a W-bit word
module popcount #(
  parameter int W = 27
) (
  input  logic [W-1:0]             d,
  output logic [$clog2(W+1)-1:0]   cnt
);
  always_comb begin
    cnt = '0;
    for (int i = 0; i < W; i++) cnt = cnt + ($clog2(W+1))'(d[i]);
  end
endmodule

// File: rtl/flit_activity_sink.sv
// flit_activity_sink: per-packet toggle activity measurement with valid/ready report output
module flit_activity_sink
  import flit_sink_pkg::*;
#(
  parameter int FLIT_W  = FLIT_W_DEF,
  parameter int OP_W    = OP_W_DEF,
  parameter int PAYLOAD = PAYLOAD_DEF,
  parameter int CNT_W   = 16,
  parameter int ACC_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flit_valid,
  input  logic [FLIT_W-1:0] flit_data,
  output logic              rpt_valid,
  input  logic              rpt_ready,
  output logic [CNT_W-1:0]  rpt_flits,
  output logic [ACC_W-1:0]  rpt_tog,
  output logic [ACC_W-1:0]  rpt_tog_lo,
  output logic [ACC_W-1:0]  rpt_tog_hi,
  output logic              rpt_err,
  output logic [CNT_W-1:0]  drop_cnt
);
  localparam int LW = $clog2(OP_W + 1);
  localparam int HW = $clog2(FLIT_W - OP_W + 1);
  if (ACC_W < acc_w_min(PAYLOAD, FLIT_W)) begin : g_acc_chk
    $error("ACC_W too small for PAYLOAD*FLIT_W toggles");
  end
  state_t state, state_nx;
  logic [FLIT_W-1:0] prev;
  logic [LW-1:0] tl;
  logic [HW-1:0] th;
  logic accept, first, last;
  logic [CNT_W-1:0] nf;
  popcount #(.W(OP_W)) u_lo (.d(flit_data[OP_W-1:0] ^ prev[OP_W-1:0]), .cnt(tl));
  popcount #(.W(FLIT_W - OP_W)) u_hi (.d(flit_data[FLIT_W-1:OP_W] ^ prev[FLIT_W-1:OP_W]), .cnt(th));
  assign rpt_valid = (state == REPORT);
  assign accept = flit_valid && (state != REPORT || rpt_ready);
  assign first = accept && state != RECV;
  assign nf = first ? CNT_W'(1) : rpt_flits + CNT_W'(1);
  assign last = (nf == CNT_W'(PAYLOAD));
  // a gap inside a packet closes it short; a retired report with no flit waiting goes idle
  always_comb
    state_nx = accept ? (last ? REPORT : RECV) :
               (state == RECV) ? REPORT :
               (state == REPORT && rpt_ready) ? IDLE : state;
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      prev       <= '0;
      rpt_flits  <= '0;
      rpt_tog    <= '0;
      rpt_tog_lo <= '0;
      rpt_tog_hi <= '0;
      rpt_err    <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        prev       <= flit_data;
        rpt_flits  <= nf;
        rpt_tog_lo <= (first ? '0 : rpt_tog_lo) + ACC_W'(tl);
        rpt_tog_hi <= (first ? '0 : rpt_tog_hi) + ACC_W'(th);
        rpt_tog    <= (first ? '0 : rpt_tog) + ACC_W'(tl) + ACC_W'(th);
        rpt_err    <= 1'b0;
      end
      if (state == RECV && !flit_valid) rpt_err <= 1'b1;
      if (state == REPORT && !rpt_ready && flit_valid && !(&drop_cnt)) drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_flit_activity_sink.sv
// tb_flit_activity_sink: directed plan plus randomized traffic against a packet-level model
module tb_flit_activity_sink;
  logic clk = 1'b0;
  logic rst, flit_valid, rpt_ready;
  logic [53:0] flit_data;
  logic rpt_valid, rpt_err;
  logic [15:0] rpt_flits, rpt_tog, rpt_tog_lo, rpt_tog_hi, drop_cnt;
  int cmp = 0, bad = 0;
  always #5 clk = ~clk;
  flit_activity_sink dut (
    .clk(clk), .rst(rst), .flit_valid(flit_valid), .flit_data(flit_data),
    .rpt_valid(rpt_valid), .rpt_ready(rpt_ready), .rpt_flits(rpt_flits),
    .rpt_tog(rpt_tog), .rpt_tog_lo(rpt_tog_lo), .rpt_tog_hi(rpt_tog_hi),
    .rpt_err(rpt_err), .drop_cnt(drop_cnt)
  );
  logic [53:0] m_prev;
  bit m_in_pkt, m_rv, m_err;
  int m_pf, m_plo, m_phi, m_flits, m_lo, m_hi, m_drop;
  task automatic chk(input string name, input longint act, input longint exp);
    cmp++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model(input bit v, input logic [53:0] d, input bit r, input bit rs);
    bit acc;
    if (rs) begin
      m_prev = '0; m_in_pkt = 0; m_rv = 0; m_err = 0;
      m_pf = 0; m_plo = 0; m_phi = 0; m_flits = 0; m_lo = 0; m_hi = 0; m_drop = 0;
      return;
    end
    acc = v && (!m_rv || r);
    if (m_rv && !r && v && m_drop < 65535) m_drop++;
    if (m_rv && r) m_rv = 0;
    if (m_in_pkt && !v) begin
      m_rv = 1; m_err = 1; m_flits = m_pf; m_lo = m_plo; m_hi = m_phi; m_in_pkt = 0;
    end
    if (acc) begin
      if (!m_in_pkt) begin m_in_pkt = 1; m_pf = 0; m_plo = 0; m_phi = 0; end
      m_pf++;
      m_plo += $countones(d[26:0] ^ m_prev[26:0]);
      m_phi += $countones(d[53:27] ^ m_prev[53:27]);
      m_prev = d;
      if (m_pf == 20) begin
        m_rv = 1; m_err = 0; m_flits = m_pf; m_lo = m_plo; m_hi = m_phi; m_in_pkt = 0;
      end
    end
  endtask
  task automatic step(input bit v, input logic [53:0] d, input bit r, input bit rs = 1'b0);
    flit_valid = v; flit_data = d; rpt_ready = r; rst = rs;
    model(v, d, r, rs);
    @(posedge clk); #1;
    chk("rpt_valid", rpt_valid, m_rv);
    chk("drop_cnt", drop_cnt, m_drop);
    if (m_rv) begin
      chk("rpt_flits", rpt_flits, m_flits);
      chk("rpt_tog_lo", rpt_tog_lo, m_lo);
      chk("rpt_tog_hi", rpt_tog_hi, m_hi);
      chk("rpt_tog", rpt_tog, m_lo + m_hi);
      chk("rpt_err", rpt_err, m_err);
    end
  endtask
  function automatic logic [53:0] rnd();
    logic [63:0] x;
    x = {$urandom, $urandom};
    return x[53:0];
  endfunction
  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, rpt_valid, 0);
    chk({tag, "_flits"}, rpt_flits, 0);
    chk({tag, "_tog"}, rpt_tog, 0);
    chk({tag, "_lo"}, rpt_tog_lo, 0);
    chk({tag, "_hi"}, rpt_tog_hi, 0);
    chk({tag, "_err"}, rpt_err, 0);
    chk({tag, "_drop"}, drop_cnt, 0);
  endtask
  initial begin
    logic [15:0] sf, st;
    step(0, '0, 0, 1);
    step(0, '0, 0, 1);
    chk_zero("reset");
    for (int i = 0; i < 20; i++) step(1, (i % 2 == 0) ? {54{1'b1}} : '0, 1);
    chk("alt_valid", rpt_valid, 1);
    chk("alt_flits", rpt_flits, 20);
    chk("alt_tog", rpt_tog, 1080);
    chk("alt_lo", rpt_tog_lo, 540);
    chk("alt_hi", rpt_tog_hi, 540);
    chk("alt_err", rpt_err, 0);
    step(0, '0, 1);
    step(1, 54'h1, 0);
    step(0, '0, 0);
    chk("one_flits", rpt_flits, 1);
    chk("one_tog", rpt_tog, 1);
    chk("one_lo", rpt_tog_lo, 1);
    chk("one_hi", rpt_tog_hi, 0);
    chk("one_err", rpt_err, 1);
    step(0, '0, 1);
    for (int i = 0; i < 5; i++) step(1, rnd(), 0);
    step(0, '0, 0);
    chk("short_flits", rpt_flits, 5);
    chk("short_err", rpt_err, 1);
    step(0, '0, 1);
    for (int i = 0; i < 20; i++) step(1, rnd(), 0);
    sf = rpt_flits; st = rpt_tog;
    step(1, rnd(), 0);
    step(1, rnd(), 0);
    step(0, '0, 0);
    chk("stall_valid", rpt_valid, 1);
    chk("stall_flits", rpt_flits, 20);
    chk("stall_tog_held", rpt_tog, st);
    chk("stall_drop", drop_cnt, 2);
    step(0, '0, 1);
    chk("stall_retired", rpt_valid, 0);
    step(0, '0, 0, 1);
    for (int i = 0; i < 40; i++) begin
      step(1, rnd(), 1);
      if (i == 19 || i == 39) begin
        chk("b2b_valid", rpt_valid, 1);
        chk("b2b_flits", rpt_flits, 20);
        chk("b2b_err", rpt_err, 0);
      end
    end
    step(0, '0, 1);
    chk("b2b_drop", drop_cnt, 0);
    for (int i = 0; i < 9; i++) step(1, rnd(), 1);
    step(1, rnd(), 1, 1);
    chk_zero("midrst");
    for (int i = 0; i < 20; i++) step(1, rnd(), 1);
    chk("postrst_flits", rpt_flits, 20);
    chk("postrst_valid", rpt_valid, 1);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 9) < 8, rnd(), $urandom_range(0, 3) != 0, $urandom_range(0, 499) == 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
